// File: rtl/read_part_fwft.sv
// Read side of the asynchronous FIFO.
// Keeps the binary read pointer and its registered Gray copy, and brings the
// write-side Gray pointer into this clock domain through two flops. It drives
// a RAM whose read data arrives one cycle after the enable, and puts that data
// into a 2-entry buffer. The buffer presents the data first-word-fall-through
// on a valid/ready interface.
module read_part_fwft #(
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_D   = 8,
    parameter int AE_THRESH = 2
) (
    input  logic               r_clk_i,
    input  logic               r_rst_i,
    input  logic [WIDTH_A:0]   w_gaddr_i,
    input  logic [WIDTH_D-1:0] ram_rdata_i,
    input  logic               dout_ready_i,
    output logic               ram_ren_o,
    output logic [WIDTH_A:0]   r_addr_o,
    output logic [WIDTH_A:0]   r_gaddr_o,
    output logic               r_empty_o,
    output logic [WIDTH_A:0]   r_level_o,
    output logic               r_almost_empty_o,
    output logic [WIDTH_D-1:0] dout_o,
    output logic               dout_valid_o
);

    localparam int PW = WIDTH_A + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]      sync1_q, sync2_q;
    logic [PW-1:0]      r_addr_q, r_addr_d;
    logic [PW-1:0]      r_gaddr_q, r_gaddr_d;
    logic [WIDTH_D-1:0] obuf_q [2];
    logic [WIDTH_D-1:0] obuf_d [2];
    logic               rd_sel_q, rd_sel_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               inflight_q, inflight_d;

    logic [PW-1:0]      w_bin_sync;
    logic [PW-1:0]      level;
    logic               empty;
    logic               pop;
    logic               ren;
    logic               wr_sel;
    logic [1:0]         occ_next;

    // Pointer view of the RAM and the read-issue decision
    always_comb begin
        w_bin_sync = gray2bin(sync2_q);
        level      = w_bin_sync - r_addr_q;
        empty      = (r_gaddr_q == sync2_q);
        pop        = (cnt_q != 2'd0) & dout_ready_i;
        // cnt + inflight never exceeds 2, and pop implies cnt >= 1, so this
        // cannot underflow or overflow two bits.
        occ_next   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        // Gating with reset keeps the RAM quiet while the state is cleared.
        ren        = ~r_rst_i & ~empty & (occ_next < 2'd2);
        // The write slot follows the oldest entry by the current occupancy.
        // When cnt is 2 this is the slot being popped this same cycle.
        wr_sel     = rd_sel_q ^ cnt_q[0];
    end

    // Next-state values for the read pointer and the output buffer
    always_comb begin
        r_addr_d   = r_addr_q;
        r_gaddr_d  = r_gaddr_q;
        rd_sel_d   = rd_sel_q ^ pop;
        cnt_d      = occ_next;
        inflight_d = ren;
        obuf_d     = obuf_q;
        if (inflight_q) begin
            obuf_d[wr_sel] = ram_rdata_i;
        end
        if (ren) begin
            r_addr_d  = r_addr_q + PW'(1);
            r_gaddr_d = bin2gray(r_addr_q + PW'(1));
        end
    end

    // Registers, with a synchronous clear of everything, including in-flight data
    always_ff @(posedge r_clk_i) begin
        if (r_rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            r_addr_q   <= '0;
            r_gaddr_q  <= '0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
            rd_sel_q   <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            sync1_q    <= w_gaddr_i;
            sync2_q    <= sync1_q;
            r_addr_q   <= r_addr_d;
            r_gaddr_q  <= r_gaddr_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
            rd_sel_q   <= rd_sel_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign ram_ren_o        = ren;
    assign r_addr_o         = r_addr_q;
    assign r_gaddr_o        = r_gaddr_q;
    assign r_empty_o        = empty;
    assign r_level_o        = level;
    assign r_almost_empty_o = (level <= AE_LIM);
    assign dout_o           = obuf_q[rd_sel_q];
    assign dout_valid_o     = (cnt_q != 2'd0);

endmodule

// File: tb/tb_read_part_fwft.sv
// Directed bench for read_part_fwft with WIDTH_A=3 so that pointer wrap is reachable.
// A behavioural write side and RAM feed the DUT. Every pushed word goes into an
// expected queue. The queue is compared in order whenever the DUT hands a word
// to the consumer.
module tb_read_part_fwft;

    localparam int WA = 3;
    localparam int WD = 8;
    localparam int PW = WA + 1;

    logic          clk;
    logic          rst;
    logic [PW-1:0] w_gaddr;
    logic [WD-1:0] ram_rdata;
    logic          dout_ready;
    logic          ram_ren;
    logic [PW-1:0] r_addr;
    logic [PW-1:0] r_gaddr;
    logic          r_empty;
    logic [PW-1:0] r_level;
    logic          r_almost_empty;
    logic [WD-1:0] dout;
    logic          dout_valid;

    logic [WD-1:0] mem [2**WA];
    logic [PW-1:0] wptr;
    logic [WD-1:0] exp_q [$];
    logic [WD-1:0] exp_word;
    int            checks = 0;
    int            errors = 0;
    int            ren_cnt = 0;

    read_part_fwft #(.WIDTH_A(WA), .WIDTH_D(WD), .AE_THRESH(2)) dut (
        .r_clk_i          (clk),
        .r_rst_i          (rst),
        .w_gaddr_i        (w_gaddr),
        .ram_rdata_i      (ram_rdata),
        .dout_ready_i     (dout_ready),
        .ram_ren_o        (ram_ren),
        .r_addr_o         (r_addr),
        .r_gaddr_o        (r_gaddr),
        .r_empty_o        (r_empty),
        .r_level_o        (r_level),
        .r_almost_empty_o (r_almost_empty),
        .dout_o           (dout),
        .dout_valid_o     (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[r_addr[WA-1:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word must be the oldest expected one
    always @(negedge clk) begin
        if (ram_ren) ren_cnt++;
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                exp_word = exp_q.pop_front();
                check("data_order", 32'(dout), 32'(exp_word));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WD-1:0] d);
        mem[wptr[WA-1:0]] = d;
        wptr    = wptr + PW'(1);
        w_gaddr = wptr ^ (wptr >> 1);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        w_gaddr    = '0;
        wptr       = '0;
        dout_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit saw_hi;
        bit saw_wrap;
        int first_v;
        int last_v;
        int nvalid;
        int n;

        rst        = 1'b1;
        w_gaddr    = '0;
        wptr       = '0;
        dout_ready = 1'b0;

        // 1: reset state
        step();
        step();
        check("rst_empty", r_empty, 1);
        check("rst_level", r_level, 0);
        check("rst_ae", r_almost_empty, 1);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_ren", ram_ren, 0);
        check("rst_addr", r_addr, 0);
        check("rst_gaddr", r_gaddr, 0);

        // 2: single word latency
        rst        = 1'b0;
        dout_ready = 1'b1;
        push(8'h5A);
        step();
        check("t2_e1_empty", r_empty, 1);
        step();
        check("t2_e2_empty", r_empty, 0);
        check("t2_e2_ren", ram_ren, 1);
        check("t2_e2_level", r_level, 1);
        step();
        check("t2_e3_ren", ram_ren, 0);
        check("t2_e3_gaddr", r_gaddr, 1);
        check("t2_e3_valid", dout_valid, 0);
        step();
        check("t2_e4_valid", dout_valid, 1);
        check("t2_e4_dout", dout, 8'h5A);
        check("t2_e4_empty", r_empty, 1);
        step();
        check("t2_e5_valid", dout_valid, 0);
        check("t2_queue", exp_q.size(), 0);

        // 3: pointer wrap with continuous reading
        do_reset();
        dout_ready = 1'b1;
        saw_hi     = 1'b0;
        saw_wrap   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'hC0 + 8'(i));
            step();
            if (r_addr[WA]) saw_hi = 1'b1;
            if (saw_hi && !r_addr[WA]) saw_wrap = 1'b1;
            check("t3_level_max", 32'(r_level <= PW'(8)), 1);
            check("t3_empty_vs_level", r_empty, 32'(r_level == '0));
        end
        n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < 30) begin
            step();
            n++;
            if (r_addr[WA]) saw_hi = 1'b1;
            if (saw_hi && !r_addr[WA]) saw_wrap = 1'b1;
            check("t3_empty_vs_level", r_empty, 32'(r_level == '0));
        end
        check("t3_drained", exp_q.size(), 0);
        check("t3_wrap_bit_set", saw_hi, 1);
        check("t3_wrap_bit_clear", saw_wrap, 1);
        check("t3_addr_wrapped", r_addr, 0);
        check("t3_empty_end", r_empty, 1);

        // 4: back-pressure holds two words, then bubble-free release
        do_reset();
        ren_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            push(8'h40 + 8'(i));
            step();
        end
        repeat (8) step();
        check("t4_reads_issued", ren_cnt, 2);
        check("t4_level", r_level, 3);
        check("t4_ae", r_almost_empty, 0);
        check("t4_valid", dout_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("t4_dout_hold", dout, 8'h40);
            step();
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stream_valid", dout_valid, 1);
            step();
        end
        check("t4_after_valid", dout_valid, 0);
        check("t4_queue", exp_q.size(), 0);

        // 5: eight words, consumer always ready
        do_reset();
        dout_ready = 1'b1;
        first_v = -1;
        last_v  = -1;
        nvalid  = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) push(8'h80 + 8'(i));
            step();
            if (dout_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nvalid++;
            end
        end
        check("t5_valid_cycles", nvalid, 8);
        check("t5_no_bubble", last_v - first_v + 1, 8);
        check("t5_queue", exp_q.size(), 0);

        // 6: reset with the buffer full, then fresh data from address 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(8'h10 + 8'(i));
            step();
        end
        check("t6_pre_valid", dout_valid, 1);
        rst     = 1'b1;
        w_gaddr = '0;
        wptr    = '0;
        exp_q.delete();
        step();
        check("t6_valid", dout_valid, 0);
        check("t6_addr", r_addr, 0);
        check("t6_level", r_level, 0);
        check("t6_empty", r_empty, 1);
        rst        = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(8'h70 + 8'(i));
            step();
        end
        drain(20);
        check("t6_addr_end", r_addr, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
